writeback_arbiter: RTL and testbench

//  Sits directly upstream of the register file and drives its single write port (dst addr/val/valid).

---
 rtl/writeback_arbiter_pkg.sv | 16 +
 rtl/writeback_arbiter_wb_fifo.sv | 64 ++++++
 rtl/writeback_arbiter.sv | 129 ++++++++++++
 tb/tb_writeback_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and default widths for the register-file writeback path.
// The widths mirror the project-wide word/register sizes.
package writeback_arbiter_pkg;

    localparam int DEF_WORD_BITS     = 32;
    localparam int DEF_REG_ADDR_BITS = 5;
    localparam int DEF_NUM_OF_REG    = 1 << DEF_REG_ADDR_BITS;

    // Source of the write issued in the current cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_ALU  = 2'd2
    } selKind_e;

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Small synchronous FIFO of {addr,val} ALU results. It also exposes per-slot
// valid/addr so the parent can check for writes still in flight.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pushEn,
    input  logic                     popEn,
    input  logic [AW-1:0]            pushAddr,
    input  logic [DW-1:0]            pushVal,
    output logic                     full,
    output logic                     empty,
    output logic [AW-1:0]            headAddr,
    output logic [DW-1:0]            headVal,
    output logic [DEPTH-1:0]         entryValid,
    output logic [DEPTH-1:0][AW-1:0] entryAddr
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [AW-1:0] addrMem [DEPTH];
    logic [DW-1:0] valMem  [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW:0]   count;
    logic          pushOk;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pushOk   = pushEn & ~full;
    assign headAddr = addrMem[rdPtr];
    assign headVal  = valMem[rdPtr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PW'(1);
            if (popEn)  rdPtr <= rdPtr + PW'(1);
            count <= count + {{PW{1'b0}}, pushOk} - {{PW{1'b0}}, popEn};
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            addrMem[wrPtr] <= pushAddr;
            valMem[wrPtr]  <= pushVal;
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
        logic [PW-1:0] offset;
        assign offset         = PW'(gi) - rdPtr;
        assign entryValid[gi] = ({1'b0, offset} < count);
        assign entryAddr[gi]  = addrMem[gi];
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges queued ALU results and load returns onto the register-file write port,
// with a starvation cap on loads and RAW pending flags for decode.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int WORD_BITS     = DEF_WORD_BITS,
    parameter int REG_ADDR_BITS = DEF_REG_ADDR_BITS,
    parameter int FIFO_DEPTH    = 4,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iAluValid,
    output logic                     oAluReady,
    input  logic [REG_ADDR_BITS-1:0] iAluDstAddr,
    input  logic [WORD_BITS-1:0]     iAluVal,
    input  logic                     iLdValid,
    output logic                     oLdReady,
    input  logic [REG_ADDR_BITS-1:0] iLdDstAddr,
    input  logic [WORD_BITS-1:0]     iLdVal,
    output logic [REG_ADDR_BITS-1:0] oDstAddr,
    output logic [WORD_BITS-1:0]     oDstVal,
    output logic                     oDstValid,
    input  logic [REG_ADDR_BITS-1:0] iQry0Addr,
    input  logic [REG_ADDR_BITS-1:0] iQry1Addr,
    output logic                     oPend0,
    output logic                     oPend1
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                                     fifoFull;
    logic                                     fifoEmpty;
    logic                                     pushEn;
    logic                                     popEn;
    logic [REG_ADDR_BITS-1:0]                 headAddr;
    logic [WORD_BITS-1:0]                     headVal;
    logic [FIFO_DEPTH-1:0]                    entryValid;
    logic [FIFO_DEPTH-1:0][REG_ADDR_BITS-1:0] entryAddr;
    logic [SW-1:0]                            starveCnt;
    logic                                     forceAlu;
    selKind_e                                 sel;
    logic [REG_ADDR_BITS-1:0]                 selAddr;
    logic [WORD_BITS-1:0]                     selVal;
    logic [1:0][REG_ADDR_BITS-1:0]            qryAddr;
    logic [1:0]                               pend;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (REG_ADDR_BITS),
        .DW    (WORD_BITS)
    ) uFifo (
        .clk        (clk),
        .rst        (rst),
        .pushEn     (pushEn),
        .popEn      (popEn),
        .pushAddr   (iAluDstAddr),
        .pushVal    (iAluVal),
        .full       (fifoFull),
        .empty      (fifoEmpty),
        .headAddr   (headAddr),
        .headVal    (headVal),
        .entryValid (entryValid),
        .entryAddr  (entryAddr)
    );

    // Loads win unless they have already starved a non-empty ALU queue too long.
    always_comb begin
        forceAlu = (starveCnt == STARVE_MAX) && !fifoEmpty;
        sel      = SEL_NONE;
        selAddr  = iLdDstAddr;
        selVal   = iLdVal;
        if (!rst) begin
            sel = SEL_NONE;
        end else if (iLdValid && !forceAlu) begin
            sel = SEL_LOAD;
        end else if (!fifoEmpty) begin
            sel     = SEL_ALU;
            selAddr = headAddr;
            selVal  = headVal;
        end
    end

    assign oAluReady = rst & ~fifoFull;
    assign oLdReady  = rst & ~forceAlu;
    assign pushEn    = iAluValid & oAluReady;
    assign popEn     = (sel == SEL_ALU);

    always_ff @(posedge clk) begin
        if (!rst) begin
            starveCnt <= '0;
        end else if (popEn || fifoEmpty) begin
            starveCnt <= '0;
        end else if (sel == SEL_LOAD && starveCnt != STARVE_MAX) begin
            starveCnt <= starveCnt + SW'(1);
        end
    end

    // Writes to r0 are swallowed: they still consume their slot but never enable the port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            oDstValid <= 1'b0;
            oDstAddr  <= '0;
            oDstVal   <= '0;
        end else begin
            oDstValid <= (sel != SEL_NONE) && (selAddr != '0);
            if (sel != SEL_NONE) begin
                oDstAddr <= selAddr;
                oDstVal  <= selVal;
            end
        end
    end

    assign qryAddr[0] = iQry0Addr;
    assign qryAddr[1] = iQry1Addr;

    for (genvar gi = 0; gi < 2; gi++) begin : gPend
        logic [FIFO_DEPTH-1:0] hit;
        for (genvar gj = 0; gj < FIFO_DEPTH; gj++) begin : gHit
            assign hit[gj] = entryValid[gj] && (entryAddr[gj] == qryAddr[gi]);
        end
        assign pend[gi] = (qryAddr[gi] != '0) &&
                          ((|hit) || (oDstValid && (oDstAddr == qryAddr[gi])));
    end

    assign oPend0 = pend[0];
    assign oPend1 = pend[1];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed scoreboard bench for writeback_arbiter against a
// queue-based reference model of the arbitration rules.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int AW    = DEF_REG_ADDR_BITS;
    localparam int DW    = DEF_WORD_BITS;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          iAluValid, oAluReady, iLdValid, oLdReady;
    logic [AW-1:0] iAluDstAddr, iLdDstAddr, oDstAddr, iQry0Addr, iQry1Addr;
    logic [DW-1:0] iAluVal, iLdVal, oDstVal;
    logic          oDstValid, oPend0, oPend1;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .WORD_BITS     (DW),
        .REG_ADDR_BITS (AW),
        .FIFO_DEPTH    (DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iAluValid   (iAluValid),
        .oAluReady   (oAluReady),
        .iAluDstAddr (iAluDstAddr),
        .iAluVal     (iAluVal),
        .iLdValid    (iLdValid),
        .oLdReady    (oLdReady),
        .iLdDstAddr  (iLdDstAddr),
        .iLdVal      (iLdVal),
        .oDstAddr    (oDstAddr),
        .oDstVal     (oDstVal),
        .oDstValid   (oDstValid),
        .iQry0Addr   (iQry0Addr),
        .iQry1Addr   (iQry1Addr),
        .oPend0      (oPend0),
        .oPend1      (oPend1)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
    } wr_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
        int            cyc;
    } exp_t;

    wr_t           mq[$];
    exp_t          expQ[$];
    int            mStarve = 0;
    bit            mLastValid = 0;
    logic [AW-1:0] mLastAddr = '0;
    bit            accepted = 0;
    int            nChecks = 0;
    int            nFails = 0;
    int            cyc = 0;
    bit            started = 0;
    exp_t          monE;
    bit            monExpV;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit mPend(input logic [AW-1:0] q);
        if (q == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == q) return 1'b1;
        return mLastValid && (mLastAddr == q);
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, advance the model.
    task automatic step(input bit r, input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                        input logic [AW-1:0] q0, input logic [AW-1:0] q1);
        bit  frc, aluRdy, ldIss, aluPop, iss, wasEmpty;
        wr_t w;
        rst = r; iAluValid = av; iAluDstAddr = aa; iAluVal = ad;
        iLdValid = lv; iLdDstAddr = la; iLdVal = ld; iQry0Addr = q0; iQry1Addr = q1;
        #1;
        wasEmpty = (mq.size() == 0);
        aluRdy   = r && (mq.size() < DEPTH);
        frc      = (mStarve == LIMIT) && !wasEmpty;
        chk("aluReady", oAluReady, aluRdy);
        chk("ldReady", oLdReady, r && !frc);
        chk("pend0", oPend0, mPend(q0));
        chk("pend1", oPend1, mPend(q1));
        iss = 0; aluPop = 0; accepted = 0;
        w.addr = '0; w.val = '0;
        if (!r) begin
            mq.delete();
            mStarve    = 0;
            mLastValid = 0;
        end else begin
            ldIss = lv && !frc;
            if (ldIss) begin
                w.addr = la; w.val = ld; iss = 1;
            end else if (!wasEmpty) begin
                w = mq.pop_front(); iss = 1; aluPop = 1;
            end
            if (aluPop || wasEmpty) mStarve = 0;
            else if (ldIss && mStarve < LIMIT) mStarve++;
            if (av && aluRdy) begin
                mq.push_back('{aa, ad});
                accepted = 1;
            end
            mLastValid = iss && (w.addr != '0);
            if (iss) mLastAddr = w.addr;
            if (mLastValid) expQ.push_back('{w.addr, w.val, cyc + 1});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input logic [AW-1:0] q0);
        for (int i = 0; i < n; i++) step(1, 0, '0, '0, 0, '0, '0, q0, '0);
    endtask

    // Monitor: every write presented on the port must match the head of the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            monExpV = (expQ.size() > 0) && (expQ[0].cyc == cyc);
            chk("dstValid", oDstValid, monExpV);
            if (monExpV) begin
                monE = expQ.pop_front();
                if (oDstValid === 1'b1) begin
                    chk("wrAddr", oDstAddr, monE.addr);
                    chk("wrVal", oDstVal, monE.val);
                end
            end
        end
    end

    initial begin
        int pushed;
        int guard;
        rst = 0; iAluValid = 1; iLdValid = 1; iAluDstAddr = 3; iLdDstAddr = 4;
        iAluVal = '0; iLdVal = '0; iQry0Addr = 3; iQry1Addr = 4;
        @(posedge clk);
        #1;
        started = 1;

        // Reset held with both producers offering.
        for (int i = 0; i < 3; i++) step(0, 1, 3, 32'h11, 1, 4, 32'h22, 3, 4);
        chk("rstAddr", oDstAddr, 0);
        chk("rstVal", oDstVal, 0);

        // Single load.
        step(1, 0, '0, '0, 1, 5, 32'hDEADBEEF, 5, 0);
        idle(2, 5);

        // ALU burst with no loads.
        pushed = 0; guard = 0;
        while (pushed < 6 && guard < 40) begin
            step(1, 1, AW'(10 + pushed), 32'hA000 + pushed, 0, '0, '0, 10, 12);
            if (accepted) pushed++;
            guard++;
        end
        chk("burstAccepted", pushed, 6);
        idle(8, 10);

        // Starvation: one queued ALU entry against a continuous load stream.
        step(1, 1, 9, 32'h9999, 1, 1, 32'h100, 9, 1);
        for (int i = 0; i < 8; i++) step(1, 0, '0, '0, 1, AW'(1 + i), 32'h200 + i, 9, AW'(1 + i));
        idle(2, 9);

        // Queue fills while loads hold the port most of the time.
        for (int i = 0; i < 12; i++)
            step(1, 1, AW'(16 + i), 32'hC000 + i, 1, AW'(2 + (i % 4)), 32'h300 + i, 16, 20);
        idle(8, 20);

        // Writes to r0 are consumed silently.
        step(1, 1, 0, 32'h5555, 1, 0, 32'h6666, 0, 0);
        idle(3, 0);

        // Pending tracking, then reset with entries still queued.
        step(1, 1, 7, 32'h7777, 0, '0, '0, 7, 0);
        idle(3, 7);
        step(1, 1, 7, 32'h7001, 1, 1, 32'h401, 7, 8);
        step(1, 1, 8, 32'h7002, 1, 2, 32'h402, 7, 8);
        step(1, 1, 12, 32'h7003, 1, 3, 32'h403, 7, 12);
        step(0, 0, '0, '0, 0, '0, '0, 7, 12);
        idle(6, 7);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) != 0, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 7)), DW'($urandom),
                 $urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), DW'($urandom),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        idle(12, 0);
        chk("scoreboardDrained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
